// File: rtl/ram_s_ctrl_if.sv
// RAM_S single-port bus: the sequencer is the master (address, write data,
// write enable), the RAM is the slave (registered read data).
interface ram_s_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] Dir;
  logic [DW-1:0] Dato_e;
  logic          EN;
  logic [DW-1:0] Dato_s;

  modport master (output Dir, Dato_e, EN, input  Dato_s);
  modport slave  (input  Dir, Dato_e, EN, output Dato_s);
endinterface

// File: rtl/ram_s_ctrl.sv
// Block-command sequencer (COPY / FILL / SUM) driving the RAM_S bus.
// Optional start-time address range check: define RAM_S_CTRL_BOUNDS_EN.
module ram_s_ctrl #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 12,
  parameter int SUMW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [AW-1:0]   src,
  input  logic [AW-1:0]   dst,
  input  logic [AW-1:0]   len,
  input  logic [DW-1:0]   fill_val,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [SUMW-1:0] sum,
  ram_s_ctrl_if.master    ram
);

  typedef enum logic [2:0] {IDLE, RD, LAT, WR, FIN} state_t;
  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_FILL = 2'b01,
    OP_SUM  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  state_t          state, state_d;
  op_t             op_q, op_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW-1:0]   len_q, len_d;
  logic [DW-1:0]   fill_q, fill_d;
  logic [AW-1:0]   cnt, cnt_d;
  logic            err_d, busy_d, done_d, en_d;
  logic [SUMW-1:0] sum_d;
  logic [AW-1:0]   dir_d;
  logic [DW-1:0]   dato_d;
  logic            bounds_fail;

`ifdef RAM_S_CTRL_BOUNDS_EN
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

  logic [AW:0] src_end, dst_end;
  logic        src_bad, dst_bad;

  // End addresses carry one extra bit so a range wrapping past 2^AW also exceeds LAST_ADDR.
  always_comb begin
    src_end     = {1'b0, src} + {1'b0, len} - (AW+1)'(1);
    dst_end     = {1'b0, dst} + {1'b0, len} - (AW+1)'(1);
    src_bad     = src_end > LAST_ADDR;
    dst_bad     = dst_end > LAST_ADDR;
    bounds_fail = 1'b0;
    if (len != '0) begin
      unique case (op_t'(op))
        OP_COPY: bounds_fail = src_bad | dst_bad;
        OP_FILL: bounds_fail = dst_bad;
        OP_SUM:  bounds_fail = src_bad;
        default: bounds_fail = 1'b0;
      endcase
    end
  end
`else
  assign bounds_fail = 1'b0;
`endif

  always_comb begin
    state_d = state;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    cnt_d   = cnt;
    err_d   = err;
    sum_d   = sum;
    dir_d   = ram.Dir;
    dato_d  = ram.Dato_e;

    unique case (state)
      IDLE: begin
        if (start) begin
          op_d   = op_t'(op);
          src_d  = src;
          dst_d  = dst;
          len_d  = len;
          fill_d = fill_val;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (op_d == OP_COPY || op_d == OP_SUM) sum_d = '0;
          if (op_d == OP_RSVD || bounds_fail) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (len == '0) begin
            state_d = FIN;
          end else if (op_d == OP_FILL) begin
            state_d = WR;
            dir_d   = dst;
            dato_d  = fill_val;
          end else begin
            state_d = RD;
            dir_d   = src;
          end
        end
      end
      RD: state_d = LAT;
      LAT: begin
        if (op_q == OP_COPY) begin
          // Read data goes straight into the write-data register for the WR cycle.
          state_d = WR;
          dir_d   = dst_q + cnt;
          dato_d  = ram.Dato_s;
        end else begin
          sum_d = sum + SUMW'(ram.Dato_s);
          cnt_d = cnt + AW'(1);
          if (cnt_d == len_q) begin
            state_d = FIN;
          end else begin
            state_d = RD;
            dir_d   = src_q + cnt_d;
          end
        end
      end
      WR: begin
        cnt_d = cnt + AW'(1);
        if (cnt_d == len_q) begin
          state_d = FIN;
        end else if (op_q == OP_COPY) begin
          state_d = RD;
          dir_d   = src_q + cnt_d;
        end else begin
          state_d = WR;
          dir_d   = dst_q + cnt_d;
          dato_d  = fill_q;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status and strobes are registered from the state being entered.
    busy_d = (state_d == RD) || (state_d == LAT) || (state_d == WR);
    done_d = (state_d == FIN);
    en_d   = (state_d == WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_COPY;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sum        <= '0;
      ram.Dir    <= '0;
      ram.Dato_e <= '0;
      ram.EN     <= 1'b0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      cnt        <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      sum        <= sum_d;
      ram.Dir    <= dir_d;
      ram.Dato_e <= dato_d;
      ram.EN     <= en_d;
    end
  end

endmodule

// File: doc/ram_s_ctrl.md
Name: ram_s_ctrl

Overview:
- Sequencing initiator that drives the single-port RAM_S interface (Dir, Dato_e, EN, Dato_s).
- Executes block commands (COPY, FILL, SUM) issued by the datapath or a testbench with a start pulse.
- Sits between control logic and the RAM; it is the only agent driving RAM address, write data and write enable.

Parameters:
- AW, 8, address width (Dir, src, dst, len)
- DW, 8, data word width
- DEPTH, 12, number of implemented RAM words (used only by the optional feature)
- SUMW, 16, SUM accumulator width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, accepted only when busy=0
- op  in  2  00=COPY, 01=FILL, 10=SUM, 11=reserved
- src  in  AW  source base address (COPY, SUM)
- dst  in  AW  destination base address (COPY, FILL)
- len  in  AW  word count
- fill_val  in  DW  FILL data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  command rejected; sticky until the next accepted start
- sum  out  SUMW  SUM result
- Dir  out  AW  RAM address
- Dato_e  out  DW  RAM write data
- EN  out  1  RAM write enable (1=write, 0=read)
- Dato_s  in  DW  RAM read data; valid one cycle after Dir is presented with EN=0

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: busy=0, done=0, err=0, sum=0, Dir=0, Dato_e=0, EN=0. State returns to IDLE.
- Reset mid-operation: EN drops immediately and asynchronously. The command is abandoned; RAM words already written stay written.
- States: IDLE, RD, LAT, WR, FIN.
- IDLE, start=1: capture op, src, dst, len and fill_val; clear word counter cnt; clear err.
  - op=COPY or SUM: clear sum, go to RD.
  - op=FILL: go to WR.
  - op=11: set err=1, go to FIN; no memory access.
  - len=0: go to FIN; no memory access.
- RD: Dir=src+cnt, EN=0.
- LAT: Dato_s is valid.
  - COPY: latch Dato_s into the data register, go to WR.
  - SUM: add zero-extended Dato_s to sum; cnt++; go to RD, or to FIN if cnt reaches len.
- WR: Dir=dst+cnt, EN=1 for exactly this cycle.
  - Dato_e = data register (COPY) or fill_val (FILL).
  - cnt++; next state is RD (COPY), WR (FILL), or FIN when cnt reaches len.
- FIN: done=1 for one cycle, busy=0, EN=0, then IDLE.
- busy=1 from the cycle after an accepted start through the last RD/LAT/WR cycle.
- Cycles per word: COPY 3, FILL 1, SUM 2. done asserts in the cycle after the last word's final state.
- start while busy=1 is ignored. start during FIN is ignored; a new command is accepted in the following IDLE cycle.
- Address arithmetic wraps modulo 2^AW; cnt is AW bits wide; len=255 is legal.
- sum wraps modulo 2^SUMW. sum holds its value until the next COPY/SUM start.
- EN=0 in every non-WR cycle. Dato_e holds its last value outside WR.
- COPY processes words in ascending order. For overlapping regions with dst>src, the result is defined by that ascending order.

Optional Feature:
- Macro: RAM_S_CTRL_BOUNDS_EN.
- Defined: at start, if any accessed address exceeds DEPTH-1, or the range wraps past 2^AW, the command is rejected.
  - Accessed range for COPY: src..src+len-1 and dst..dst+len-1.
  - Accessed range for FILL: dst..dst+len-1.
  - Accessed range for SUM: src..src+len-1.
  - Rejection sets err=1, goes straight to FIN, and performs no RD/WR cycles (EN never asserted).
- Not defined: no check; addresses wrap as stated above.

Test Plan:
- RAM initialised 90,80,...,10,100,101,102; SUM src=0 len=3 -> done after 6 busy cycles, sum=240, EN never high.
- COPY src=0 dst=9 len=3 -> exactly 3 EN pulses at Dir=9,10,11 with Dato_e=90,80,70; a following SUM src=9 len=3 gives sum=240.
- FILL dst=4 len=2 fill_val=0xAA -> EN high two consecutive cycles at Dir=4,5 with Dato_e=0xAA; SUM src=4 len=2 gives sum=340.
- len=0 on any op, and op=11 -> done pulse 1 cycle after start, no EN; err=1 only for op=11, cleared by the next accepted start.
- Start pulse while busy during COPY len=3 -> ignored; assert rst_n=0 mid-COPY -> EN, busy, done go to 0 immediately; sum=0.
- RAM_S_CTRL_BOUNDS_EN defined: FILL dst=10 len=3 -> err=1, done pulse, no EN. Not defined: same command writes Dir=10,11,12.
